// File: rtl/hazard_detection_unit.sv
// Hazard detection unit for the 5-stage MIPS pipeline, IF/ID boundary.
// Catches hazards that EX-stage forwarding cannot cover (load-use, and ID-stage
// branch operands still in flight). It stalls PC and IF/ID, bubbles ID/EX,
// flushes IF/ID on taken branches and jumps, and counts stalls and flushes.
module hazard_detection_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IF_ID_Rs,
  input  logic [4:0]       IF_ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             ID_Branch,
  input  logic             ID_Taken,
  input  logic             ID_EX_MemRead,
  input  logic             ID_EX_RegWrite,
  input  logic [4:0]       ID_EX_Rd,
  input  logic             EX_MEM_MemRead,
  input  logic [4:0]       EX_MEM_Rd,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             ID_EX_Bubble,
  output logic             IF_ID_Flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     state_q, state_d;
  // Remaining HOLD cycles, including the one currently in progress.
  logic [1:0] cnt_q, cnt_d;

  logic match_e, match_m;
  logic haz_1, haz_2;

  // Register-match and hazard classification; $0 never matches.
  always_comb begin
    match_e = (ID_EX_Rd != 5'd0) &&
              ((ID_EX_Rd == IF_ID_Rs) || (ID_UsesRt && (ID_EX_Rd == IF_ID_Rt)));
    match_m = (EX_MEM_Rd != 5'd0) &&
              ((EX_MEM_Rd == IF_ID_Rs) || (ID_UsesRt && (EX_MEM_Rd == IF_ID_Rt)));
    // A branch waiting on a load in EX needs two cycles: one for the load
    // to reach MEM and one more for the data to come back.
    haz_2 = ID_Branch && ID_EX_MemRead && match_e;
    haz_1 = !haz_2 &&
            ((ID_EX_MemRead && match_e && !ID_Branch) ||
             (ID_Branch && ID_EX_RegWrite && !ID_EX_MemRead && match_e) ||
             (ID_Branch && EX_MEM_MemRead && match_m));
  end

  // Next-state logic: RUN re-evaluates every cycle, HOLD counts down.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; a missed path in always_comb would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (haz_2) begin
          state_d = HOLD;
          cnt_d   = 2'd1;
        end
      end
      HOLD: begin
        if (cnt_q <= 2'd1) begin
          state_d = RUN;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // Output logic: Mealy in RUN, state-only in HOLD, forced benign under reset.
  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Bubble = 1'b0;
    IF_ID_Flush  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        RUN: begin
          if (haz_1 || haz_2) begin
            // The branch is unresolved while stalled, so ID_Taken is ignored.
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
          end else begin
            IF_ID_Flush = ID_Taken;
          end
        end
        HOLD: begin
          PC_Write     = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // State register; reset abandons any stall in progress.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Saturating performance counters for stall cycles and flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!PC_Write && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (IF_ID_Flush && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Scoreboard bench for hazard_detection_unit (CNT_W=4 so saturation is reachable).
// The driver applies one directed vector per cycle and queues the hand-computed
// response; an independent monitor pops and compares on the falling edge.
module tb_hazard_detection_unit;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       IF_ID_Rs, IF_ID_Rt, ID_EX_Rd, EX_MEM_Rd;
  logic             ID_UsesRt, ID_Branch, ID_Taken;
  logic             ID_EX_MemRead, ID_EX_RegWrite, EX_MEM_MemRead;
  logic             PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  typedef struct {
    string          name;
    logic           pcw;
    logic           ifw;
    logic           bub;
    logic           fl;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_detection_unit #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .IF_ID_Rs       (IF_ID_Rs),
    .IF_ID_Rt       (IF_ID_Rt),
    .ID_UsesRt      (ID_UsesRt),
    .ID_Branch      (ID_Branch),
    .ID_Taken       (ID_Taken),
    .ID_EX_MemRead  (ID_EX_MemRead),
    .ID_EX_RegWrite (ID_EX_RegWrite),
    .ID_EX_Rd       (ID_EX_Rd),
    .EX_MEM_MemRead (EX_MEM_MemRead),
    .EX_MEM_Rd      (EX_MEM_Rd),
    .PC_Write       (PC_Write),
    .IF_ID_Write    (IF_ID_Write),
    .ID_EX_Bubble   (ID_EX_Bubble),
    .IF_ID_Flush    (IF_ID_Flush),
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
  );

  task automatic check(input string name, input logic [CNT_W-1:0] act,
                       input logic [CNT_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: compares every queued expectation against the DUT mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".PC_Write"},     CNT_W'(PC_Write),     CNT_W'(e.pcw));
        check({e.name, ".IF_ID_Write"},  CNT_W'(IF_ID_Write),  CNT_W'(e.ifw));
        check({e.name, ".ID_EX_Bubble"}, CNT_W'(ID_EX_Bubble), CNT_W'(e.bub));
        check({e.name, ".IF_ID_Flush"},  CNT_W'(IF_ID_Flush),  CNT_W'(e.fl));
        check({e.name, ".stall_cycles"}, stall_cycles,         e.stall);
        check({e.name, ".flush_count"},  flush_count,          e.flush);
      end
    end
  end

  // One cycle: drive inputs after the rising edge and queue the expected response.
  task automatic cyc(input string name, input logic r,
                     input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                     input logic br, input logic tk,
                     input logic ex_mr, input logic ex_rw, input logic [4:0] ex_rd,
                     input logic mem_mr, input logic [4:0] mem_rd,
                     input logic pcw, input logic ifw, input logic bub, input logic fl,
                     input int st, input int fc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; IF_ID_Rs = rs; IF_ID_Rt = rt; ID_UsesRt = uses_rt;
    ID_Branch = br; ID_Taken = tk;
    ID_EX_MemRead = ex_mr; ID_EX_RegWrite = ex_rw; ID_EX_Rd = ex_rd;
    EX_MEM_MemRead = mem_mr; EX_MEM_Rd = mem_rd;
    e.name = name; e.pcw = pcw; e.ifw = ifw; e.bub = bub; e.fl = fl;
    e.stall = CNT_W'(st); e.flush = CNT_W'(fc);
    exp_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    {IF_ID_Rs, IF_ID_Rt, ID_EX_Rd, EX_MEM_Rd} = '0;
    {ID_UsesRt, ID_Branch, ID_Taken, ID_EX_MemRead, ID_EX_RegWrite, EX_MEM_MemRead} = '0;
    repeat (2) @(posedge clk);

    //       name            rst rs  rt  ut br tk emr erw erd mmr mrd  pcw ifw bub fl st fc
    // Reset held with a load-use present: outputs forced benign, counters 0.
    cyc("reset",         1, 2,  0,  1, 0, 0, 1, 1, 2,  0, 0,   1, 1, 0, 0, 0, 0);
    // Load-use: lw $2 in EX, add reading $2 -> one stall, then bubble in EX.
    cyc("lu_stall",      0, 2,  0,  1, 0, 0, 1, 1, 2,  0, 0,   0, 0, 1, 0, 0, 0);
    cyc("lu_release",    0, 2,  0,  1, 0, 0, 0, 0, 0,  0, 0,   1, 1, 0, 0, 1, 0);
    // lw $5 in EX, beq on Rt=5 -> RUN stall, HOLD stall (inputs changed), RUN.
    cyc("h2_run",        0, 1,  5,  1, 1, 1, 1, 1, 5,  0, 0,   0, 0, 1, 0, 1, 0);
    cyc("h2_hold",       0, 0,  0,  0, 0, 1, 0, 0, 0,  0, 0,   0, 0, 1, 0, 2, 0);
    cyc("h2_done",       0, 1,  5,  1, 1, 0, 0, 0, 0,  0, 0,   1, 1, 0, 0, 3, 0);
    // Taken beq on $3 with add $3 in EX: stall suppresses flush, then flush.
    cyc("br_alu_stall",  0, 3,  0,  1, 1, 1, 0, 1, 3,  0, 0,   0, 0, 1, 0, 3, 0);
    cyc("br_flush",      0, 3,  0,  1, 1, 1, 0, 0, 0,  0, 0,   1, 1, 0, 1, 4, 0);
    cyc("br_after",      0, 0,  0,  0, 0, 0, 0, 0, 0,  0, 0,   1, 1, 0, 0, 4, 1);
    // beq on $4 with a load of $4 in MEM -> one stall.
    cyc("br_mem_stall",  0, 4,  0,  1, 1, 0, 0, 0, 0,  1, 4,   0, 0, 1, 0, 4, 1);
    cyc("br_mem_after",  0, 0,  0,  0, 0, 0, 0, 0, 0,  0, 0,   1, 1, 0, 0, 5, 1);
    // $0 and unused-Rt matches never stall.
    cyc("zero_reg",      0, 0,  0,  1, 0, 0, 1, 1, 0,  0, 0,   1, 1, 0, 0, 5, 1);
    cyc("rt_unused",     0, 1,  7,  0, 0, 0, 1, 1, 7,  0, 0,   1, 1, 0, 0, 5, 1);
    cyc("zero_mem_br",   0, 0,  0,  1, 1, 1, 0, 0, 0,  1, 0,   1, 1, 0, 1, 5, 1);
    cyc("zero_mem_aft",  0, 0,  0,  0, 0, 0, 0, 0, 0,  0, 0,   1, 1, 0, 0, 5, 2);
    // Reset asserted during the HOLD cycle of a two-cycle stall.
    cyc("rh_run",        0, 6,  0,  1, 1, 0, 1, 1, 6,  0, 0,   0, 0, 1, 0, 5, 2);
    cyc("rh_reset",      1, 6,  0,  1, 1, 0, 1, 1, 6,  0, 0,   1, 1, 0, 0, 6, 2);
    cyc("rh_after",      0, 0,  0,  0, 0, 0, 0, 0, 0,  0, 0,   1, 1, 0, 0, 0, 0);

    // Twenty back-to-back load-use stalls: counter stops at 15.
    for (int k = 0; k < 20; k++)
      cyc($sformatf("sat_stall%0d", k), 0, 9, 0, 1, 0, 0, 1, 1, 9, 0, 0,
          0, 0, 1, 0, (k < 15) ? k : 15, 0);
    cyc("sat_stall_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 15, 0);
    // Twenty jumps in a row: flush counter stops at 15.
    for (int k = 0; k < 20; k++)
      cyc($sformatf("sat_flush%0d", k), 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,
          1, 1, 0, 1, 15, (k < 15) ? k : 15);
    cyc("sat_flush_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 15, 15);

    // Let the monitor drain the queue, within a bounded number of cycles.
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
